uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide 8N1 UART transmitter for the UART subsystem: the outbound counterpart to the input-side conditioning (tick divider plus shift register) used on the receive/button path. Accepts a one-cycle start pulse, typically the edge pulse from the button debouncer or a controller, latches a byte, and serialises it LSB-first on `tx` using an internal bit-period counter. Reports busy for the whole frame and a one-cycle done pulse at frame end.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate in bit/s.
- `BAUD_DIV`, CLK_FREQ / BAUD (integer division; 10416 at defaults), clocks per bit. Legal range is 2 or greater. Overridable directly for simulation.

- `clk`, input, 1, system clock, rising edge.
- `reset`, input, 1, asynchronous, active-low reset.
- `tx_start`, input, 1, request to send `tx_data`. Sampled on rising edges; honoured only in IDLE.
- `tx_data`, input, 8, byte to send. Sampled only on the accepting edge.
- `tx`, output, 1, serial line. Registered; idle high.
- `tx_busy`, output, 1, high from the accepting edge until the frame ends.
- `tx_done`, output, 1, one-cycle pulse marking frame completion.

## Operation
- FSM states:
  - IDLE: `tx`=1, `tx_busy`=0.
  - START: `tx`=0.
  - DATA: `tx` = shift_reg[0].
  - STOP: `tx`=1.
- IDLE to START: on an edge where `tx_start`=1.
  - On that edge, `tx_data` is latched into shift_reg, the bit counter and bit index clear, and `tx_busy`=1.
- Bit period: the counter runs 0..BAUD_DIV-1. The state advances on the edge where counter = BAUD_DIV-1, and the counter wraps to 0.
  - Counter width is $clog2(BAUD_DIV).
- START to DATA after one bit period.
- DATA: one bit per period, LSB first.
  - shift_reg shifts right at each period end.
  - The 3-bit index counts 0..7. Leave DATA after the period with index 7.
- DATA to STOP.
- STOP to IDLE after one bit period. On that edge `tx_done`=1 for one cycle and `tx_busy`=0.
- `tx_start` while not IDLE is ignored entirely. No queueing, no effect on the frame.
- `tx_data` changes after acceptance do not affect the frame in flight.
- `tx_start` held high continuously: a new frame is accepted every time IDLE is entered.
- Reset (`reset`=0, asynchronous, any state including mid-frame):
  - State becomes IDLE; counters and shift_reg clear.
  - `tx`=1, `tx_busy`=0, `tx_done`=0, applied immediately.
  - The partial frame is abandoned; nothing resumes after release.

## Timing
- Accept edge at cycle A: `tx` falls and `tx_busy` rises, both visible right after A (one registered stage, no further latency).
- Per-bit timing for bit k (0 = start, 1..8 = data bits 0..7, 9 = stop):
  - Driven from A + k·BAUD_DIV.
  - Held exactly BAUD_DIV cycles.
- Frame length is exactly 10·BAUD_DIV cycles.
  - `tx_done` is high and `tx_busy` is low in the cycle after edge A + 10·BAUD_DIV.
- Back-to-back frames: `tx_start` high during the `tx_done` cycle (state IDLE) is accepted.
  - Minimum spacing between start bits is 10·BAUD_DIV + 1 cycles, i.e. one extra idle-high cycle between frames.
- `tx` never glitches. It changes only on bit boundaries or reset.

## Test plan
All scenarios use BAUD_DIV=16.
- Reset:
  - Assert `reset`=0 for 5 cycles, then release.
  - Required: `tx`=1, `tx_busy`=0, `tx_done`=0 throughout and afterwards with `tx_start`=0.
- Byte 0x55:
  - Pulse `tx_start` once with `tx_data`=0x55.
  - Required `tx` sequence: 0,1,0,1,0,1,0,1,0,1, each exactly 16 cycles.
  - `tx_busy` high for 160 cycles; a single `tx_done` pulse at accept+160.
- Byte 0xA5, LSB-first ordering:
  - Required data bits on the line: 1,0,1,0,0,1,0,1, framed by 0 and 1.
  - Bench receiver model reconstructs 0xA5.
- Ignore while busy:
  - Send 0x3C, then at accept+40 pulse `tx_start` with `tx_data`=0xFF and hold `tx_data`=0xFF.
  - Required: the line still carries 0x3C, exactly one `tx_done`, no second frame.
- Back-to-back:
  - Send 0x12, then assert `tx_start` with 0x34 during the `tx_done` cycle.
  - Required: the 0x34 start bit begins at the next edge, 161 cycles after the first accept.
  - Two `tx_done` pulses, 161 cycles apart.
- Mid-frame reset:
  - Send 0xF0 and assert `reset`=0 during data bit 3 (accept+70).
  - Required: `tx`=1 and `tx_busy`=0 immediately, with no `tx_done`.
  - After release, sending 0x81 produces a clean full 160-cycle frame.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, with registered line, busy and done outputs
module uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CW = $clog2(BAUD_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift_reg, shift_n;
  logic          tick, tx_n, busy_n, done_n;
  assign tick = cnt == CW'(BAUD_DIV - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    shift_n = shift_reg;
    if (state == IDLE) begin
      if (tx_start) begin
        state_n = START;
        shift_n = tx_data;
        cnt_n = '0;
        idx_n = '0;
      end
    end else begin
      cnt_n = tick ? '0 : cnt + CW'(1);
      if (tick) begin
        state_n = state == START ? DATA : state == STOP ? IDLE : idx == 3'd7 ? STOP : DATA;
        if (state == DATA) begin
          shift_n = shift_reg >> 1;
          idx_n = idx + 3'd1;
        end
      end
    end
    // outputs are registered from the next state so tx moves exactly on bit boundaries
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
    busy_n = state_n != IDLE;
    done_n = state == STOP && tick;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift_reg <= '0;
      tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift_reg <= shift_n;
      tx <= tx_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed frame checks of uart_tx against a bit-timeline model
module tb_uart_tx;
  localparam int D = 16;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, tx_done;
  int         n_vec = 0;
  int         n_err = 0;

  uart_tx #(.BAUD_DIV(D)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_tx", tx, 1);
      check("idle_busy", tx_busy, 0);
      check("idle_done", tx_done, 0);
      @(negedge clk);
    end
  endtask

  task automatic drive_start(input logic [7:0] b);
    tx_start = 1'b1;
    tx_data = b;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // called at the first negedge after the accepting edge; ends one cycle after the done cycle
  task automatic check_frame(input logic [7:0] b, input bit noise, input int ign_at,
                             input bit btb, input logic [7:0] nb, input int abort_at);
    logic [9:0] bits;
    logic [7:0] rx;
    bits = {1'b1, b, 1'b0};
    rx = 8'h00;
    for (int t = 0; t <= 10 * D; t++) begin
      if (t < 10 * D) begin
        check("tx_bit", tx, bits[t / D]);
        check("busy", tx_busy, 1);
        check("done_early", tx_done, 0);
        if (t % D == D / 2 && t / D >= 1 && t / D <= 8) rx[t / D - 1] = tx;
      end else begin
        check("stop_tx", tx, 1);
        check("busy_end", tx_busy, 0);
        check("done_pulse", tx_done, 1);
        check("rx_byte", rx, b);
      end
      if (t == abort_at) begin
        #2 reset = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("rst_hold_tx", tx, 1);
          check("rst_hold_busy", tx_busy, 0);
          check("rst_hold_done", tx_done, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        return;
      end
      if (t < 10 * D) begin
        tx_start = (t == ign_at) | (noise & ($urandom_range(0, 3) == 0));
        if (noise) tx_data = 8'($urandom);
        if (t == ign_at) tx_data = 8'hFF;
      end else begin
        tx_start = btb;
        tx_data = nb;
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
  endtask

  initial begin
    logic [7:0] b, nb;
    bit btb, chained;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_busy", tx_busy, 0);
      check("reset_done", tx_done, 0);
    end
    reset = 1'b1;
    idle_check(5);

    drive_start(8'h55);
    check_frame(8'h55, 0, -1, 0, 8'h00, -1);
    idle_check(3);

    drive_start(8'hA5);
    check_frame(8'hA5, 0, -1, 0, 8'h00, -1);
    idle_check(3);

    drive_start(8'h3C);
    check_frame(8'h3C, 0, 40, 0, 8'hFF, -1);
    idle_check(2 * D);

    drive_start(8'h12);
    check_frame(8'h12, 0, -1, 1, 8'h34, -1);
    check_frame(8'h34, 0, -1, 0, 8'h00, -1);
    idle_check(3);

    drive_start(8'hF0);
    check_frame(8'hF0, 0, -1, 0, 8'h00, 70);
    idle_check(2 * D);
    drive_start(8'h81);
    check_frame(8'h81, 0, -1, 0, 8'h00, -1);
    idle_check(3);

    chained = 1'b0;
    b = 8'($urandom);
    for (int i = 0; i < 24; i++) begin
      if (!chained) drive_start(b);
      nb = 8'($urandom);
      btb = 1'($urandom_range(0, 1));
      check_frame(b, 1, -1, btb, nb, -1);
      if (!btb) idle_check($urandom_range(1, 6));
      chained = btb;
      b = nb;
    end
    if (chained) check_frame(b, 0, -1, 0, 8'h00, -1);
    idle_check(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
